// File: rtl/load_store_unit.sv
// Memory stage: one data-memory transaction per op with a req/ack handshake and a bus timeout.
// Returns aligned, extended load data and reports misaligned, illegal or timed-out ops.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] load_data
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state, state_next;
   logic        load_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] sd_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [7:0]  cnt;

   logic        illegal;
   logic        misaligned;
   logic        timeout_hit;
   logic [31:0] shifted;
   logic [31:0] ext;

   always_comb begin
      illegal = (is_load == is_store);
      if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
         illegal = 1'b1;
      if (is_store && (funct3[2] || funct3[1:0] == 2'b11))
         illegal = 1'b1;
      misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
   end

   // Ack in the final wait cycle takes priority over the timeout.
   assign timeout_hit = (cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_valid) state_next = (illegal || misaligned) ? DONE : WAIT;
         WAIT: if (mem_ack || timeout_hit) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q  <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         sd_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               load_q <= is_load;
               f3_q   <= funct3;
               addr_q <= addr;
               sd_q   <= store_data;
               err_q  <= illegal || misaligned;
               cnt    <= '0;
            end
            WAIT: begin
               cnt <= cnt + 8'd1;
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign mem_req    = (state == WAIT);
   assign mem_we     = mem_req && !load_q;
   assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;

   always_comb begin
      mem_wdata = '0;
      mem_be    = '0;
      if (mem_req) begin
         if (load_q) begin
            mem_be = 4'b1111;
         end else begin
            case (f3_q[1:0])
               2'b00: begin
                  mem_wdata = {4{sd_q[7:0]}};
                  mem_be    = 4'b0001 << addr_q[1:0];
               end
               2'b01: begin
                  mem_wdata = {2{sd_q[15:0]}};
                  mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
               end
               default: begin
                  mem_wdata = sd_q;
                  mem_be    = 4'b1111;
               end
            endcase
         end
      end
   end

   assign shifted = rdata_q >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'd0, shifted[7:0]};
         3'b101:  ext = {16'd0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   assign resp_valid = (state == DONE);
   assign resp_err   = resp_valid && err_q;
   assign load_data  = (resp_valid && !err_q && load_q) ? ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 4-cycle bus timeout.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] load_data;

   int checks = 0;
   int failures = 0;

   // results of the most recent run_op
   logic        o_seen;
   logic        o_we;
   logic [31:0] o_addr;
   logic [31:0] o_wdata;
   logic [3:0]  o_be;
   logic        o_err;
   logic [31:0] o_data;
   int          o_lat;
   int          o_reqs;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
      .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data)
   );

   // Present one op, ack in the ack_at-th mem_req cycle (0 = never), wait for the response.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int ack_at);
      o_seen = 1'b0; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0;
      o_err = 1'b0; o_data = '0; o_lat = -1; o_reqs = 0;
      is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (resp_valid) begin
            o_lat  = cyc;
            o_err  = resp_err;
            o_data = load_data;
            break;
         end
         if (mem_req) begin
            o_reqs++;
            if (!o_seen) begin
               o_seen = 1'b1; o_we = mem_we; o_addr = mem_addr;
               o_wdata = mem_wdata; o_be = mem_be;
            end
            if (o_reqs == ack_at) begin
               mem_ack = 1'b1;
               mem_rdata = rd;
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      checks++;
      if (o_lat < 0) begin
         failures++;
         $display("FAIL resp_timeout got=no resp_valid exp=resp_valid within 40 cycles");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++;
      if ({mem_req, mem_we, resp_valid, resp_err} !== 4'b0000) begin
         failures++; $display("FAIL reset_ctl got=%b exp=0000", {mem_req, mem_we, resp_valid, resp_err});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_be, load_data} !== '0) begin
         failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, mem_be, load_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lw;
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
      checks++;
      if (o_seen !== 1'b1 || o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
         failures++; $display("FAIL lw_bus got=req%b addr=%h be=%b we=%b exp=req1 addr=00000100 be=1111 we=0", o_seen, o_addr, o_be, o_we);
      end
      checks++;
      if (o_lat != 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", o_lat); end
      checks++;
      if (o_err !== 1'b0 || o_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL lw_data got=err%b %h exp=err0 deadbeef", o_err, o_data);
      end
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++; $display("FAIL lw_pulse got=valid%b ready%b exp=valid0 ready1", resp_valid, req_ready);
      end
   endtask

   task automatic test_load_ext;
      run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1);
      checks++;
      if (o_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", o_data); end
      run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
      checks++;
      if (o_data !== 32'h00000080 || o_lat != 3) begin
         failures++; $display("FAIL lbu_zext got=%h lat=%0d exp=00000080 lat=3", o_data, o_lat);
      end
      run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1);
      checks++;
      if (o_data !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_sext got=%h exp=ffff80ff", o_data); end
      run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1);
      checks++;
      if (o_data !== 32'h000080FF) begin failures++; $display("FAIL lhu_zext got=%h exp=000080ff", o_data); end
      run_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h80FF1234, 1);
      checks++;
      if (o_data !== 32'h00000012) begin failures++; $display("FAIL lbu_off1 got=%h exp=00000012", o_data); end
   endtask

   task automatic test_store;
      run_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1);
      checks++;
      if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_addr !== 32'h20) begin
         failures++; $display("FAIL sh_bus got=we%b be=%b wd=%h a=%h exp=we1 be=1100 wd=abcdabcd a=00000020", o_we, o_be, o_wdata, o_addr);
      end
      checks++;
      if (o_err !== 1'b0 || o_data !== 32'h0) begin
         failures++; $display("FAIL sh_resp got=err%b data=%h exp=err0 data=0", o_err, o_data);
      end
      run_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234565A, 32'h0, 1);
      checks++;
      if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A5A5A) begin
         failures++; $display("FAIL sb_bus got=be=%b wd=%h exp=be=0010 wd=5a5a5a5a", o_be, o_wdata);
      end
      run_op(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1);
      checks++;
      if (o_be !== 4'b1111 || o_wdata !== 32'h12345678 || o_addr !== 32'h40) begin
         failures++; $display("FAIL sw_bus got=be=%b wd=%h a=%h exp=be=1111 wd=12345678 a=00000040", o_be, o_wdata, o_addr);
      end
   endtask

   task automatic test_errors;
      logic [2:0]  f3s [5] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b010};
      logic [31:0] as  [5] = '{32'h102, 32'h100, 32'h100, 32'h23, 32'h100};
      logic        lds [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        sts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         run_op(lds[i], sts[i], f3s[i], as[i], 32'hFFFF, 32'h11223344, 1);
         checks++;
         if (o_seen !== 1'b0 || o_lat != 1 || o_err !== 1'b1 || o_data !== 32'h0) begin
            failures++; $display("FAIL err_case%0d got=req%b lat=%0d err%b data=%h exp=req0 lat=1 err1 data=0", i, o_seen, o_lat, o_err, o_data);
         end
      end
   endtask

   task automatic test_timeout;
      run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 0);
      checks++;
      if (o_reqs != 4 || o_lat != 5 || o_err !== 1'b1 || o_data !== 32'h0) begin
         failures++; $display("FAIL timeout got=reqs%0d lat%0d err%b data=%h exp=reqs4 lat5 err1 data=0", o_reqs, o_lat, o_err, o_data);
      end
      run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 4);
      checks++;
      if (o_reqs != 4 || o_lat != 5 || o_err !== 1'b0 || o_data !== 32'hCAFEF00D) begin
         failures++; $display("FAIL ack_at_limit got=reqs%0d lat%0d err%b data=%h exp=reqs4 lat5 err0 data=cafef00d", o_reqs, o_lat, o_err, o_data);
      end
   endtask

   task automatic test_back_to_back;
      run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h01020304, 1);
      run_op(1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 32'h0000FF00, 1);
      checks++;
      if (o_data !== 32'hFFFFFFFF || o_lat != 2) begin
         failures++; $display("FAIL back_to_back got=%h lat%0d exp=ffffffff lat2", o_data, o_lat);
      end
   endtask

   task automatic test_reset_mid_wait;
      is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1) begin failures++; $display("FAIL pre_reset_req got=%b exp=1", mem_req); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
         failures++; $display("FAIL async_reset got=req%b ready%b exp=req0 ready1", mem_req, req_ready);
      end
      #2 rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL late_ack_%0d got=valid%b req%b exp=valid0 req0", i, resp_valid, mem_req);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_load_ext;
      test_store;
      test_errors;
      test_timeout;
      test_back_to_back;
      test_reset_mid_wait;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
